player_laser: RTL

PLAYER_LASER -- requirements
Module: player_laser

---
 rtl/space_pkg.sv | 15 +
 rtl/counter.sv | 34 +++
 rtl/player_laser.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/space_pkg.sv
// Shared definitions for the player and laser blocks: laser FSM states and
// playfield border constants.
package space_pkg;

  typedef enum logic [1:0] {
    LASER_IDLE     = 2'd0,
    LASER_FLIGHT   = 2'd1,
    LASER_COOLDOWN = 2'd2
  } laser_state_e;

  localparam logic [9:0] top_border   = 10'd8;
  localparam logic [9:0] left_border  = 10'd9;
  localparam logic [9:0] right_border = 10'd630;

endpackage

// File: rtl/counter.sv
// Loadable down counter that saturates at zero; load takes priority over down.
module counter #(
  parameter int unsigned width_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               load_i,
  input  logic [width_p-1:0] load_val_i,
  input  logic               down_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (down_i && (count_q != '0)) begin
      count_d = count_q - {{(width_p-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/player_laser.sv
// Player laser: fire on shoot edge, climb one step per frame tick, then cool down.
// Define PLAYER_LASER_AUTOFIRE_EN to fire on a held shoot_i level instead of edges.
module player_laser
  import space_pkg::*;
#(
  parameter logic [11:0] color_p    = 12'hF00,
  parameter logic [9:0]  step_p     = 10'd8,
  parameter logic [9:0]  spawn_y_p  = 10'd440,
  parameter logic [9:0]  laser_h_p  = 10'd12,
  parameter logic [3:0]  cooldown_p = 4'd3
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       frame_tick_i,
  input  logic       shoot_i,
  input  logic       alive_i,
  input  logic       freeze_i,
  input  logic [9:0] gun_pos_i,
  input  logic       hit_target_i,
  output logic       fired_o,
  output logic       miss_o,
  output logic       laser_active_o,
  output logic [9:0] laser_x_o,
  output logic [9:0] laser_y_top_o,
  output logic [9:0] laser_y_bot_o,
  output logic [3:0] laser_red_o,
  output logic [3:0] laser_green_o,
  output logic [3:0] laser_blue_o,
  output logic [1:0] state_o
);

  laser_state_e state_q, state_d;
  logic         shoot_prev_q;
  logic         fired_q, fired_d;
  logic         miss_q, miss_d;
  logic [9:0]   x_q, x_d;
  logic [9:0]   y_q, y_d;
  logic         cd_load, cd_down;
  logic [3:0]   cd_count;
  logic         fire_req;
  logic         tick_run;
  logic         in_flight;

`ifdef PLAYER_LASER_AUTOFIRE_EN
  assign fire_req = shoot_i;
`else
  assign fire_req = shoot_i & ~shoot_prev_q;
`endif

  assign tick_run = frame_tick_i & ~freeze_i;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    fired_d = 1'b0;
    miss_d  = 1'b0;
    cd_load = 1'b0;
    cd_down = 1'b0;
    case (state_q)
      LASER_IDLE: begin
        if (alive_i && !freeze_i && fire_req) begin
          state_d = LASER_FLIGHT;
          x_d     = gun_pos_i;
          y_d     = spawn_y_p;
          fired_d = 1'b1;
        end
      end
      LASER_FLIGHT: begin
        // Priority: death, then hit, then a tick (which may leave the top).
        if (!alive_i) begin
          state_d = LASER_IDLE;
          x_d     = '0;
          y_d     = '0;
        end else if (hit_target_i) begin
          state_d = LASER_COOLDOWN;
          cd_load = 1'b1;
          x_d     = '0;
          y_d     = '0;
        end else if (tick_run) begin
          if (y_q < (top_border + step_p)) begin
            state_d = LASER_COOLDOWN;
            cd_load = 1'b1;
            miss_d  = 1'b1;
            x_d     = '0;
            y_d     = '0;
          end else begin
            y_d = y_q - step_p;
          end
        end
      end
      LASER_COOLDOWN: begin
        if (!alive_i || (cd_count == '0)) begin
          state_d = LASER_IDLE;
        end else if (tick_run) begin
          cd_down = 1'b1;
          if (cd_count == 4'd1) begin
            state_d = LASER_IDLE;
          end
        end
      end
      default: begin
        state_d = LASER_IDLE;
        x_d     = '0;
        y_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= LASER_IDLE;
      shoot_prev_q <= 1'b0;
      fired_q      <= 1'b0;
      miss_q       <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
    end else begin
      state_q      <= state_d;
      shoot_prev_q <= shoot_i;
      fired_q      <= fired_d;
      miss_q       <= miss_d;
      x_q          <= x_d;
      y_q          <= y_d;
    end
  end

  counter #(
    .width_p(4)
  ) u_cooldown (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .load_i    (cd_load),
    .load_val_i(cooldown_p),
    .down_i    (cd_down),
    .count_o   (cd_count)
  );

  assign in_flight      = (state_q == LASER_FLIGHT);
  assign fired_o        = fired_q;
  assign miss_o         = miss_q;
  assign laser_active_o = in_flight;
  assign laser_x_o      = in_flight ? x_q : '0;
  assign laser_y_top_o  = in_flight ? y_q : '0;
  assign laser_y_bot_o  = in_flight ? (y_q + laser_h_p) : '0;
  assign laser_red_o    = color_p[11:8];
  assign laser_green_o  = color_p[7:4];
  assign laser_blue_o   = color_p[3:0];
  assign state_o        = state_q;

endmodule
